// File: rtl/fdma_wr_frame_ctrl.sv
// Write-side frame controller for app_fdma: buffers a 32-bit pixel stream in a FIFO and
// moves each frame into a rotating set of SDRAM frame buffers as fixed-size write bursts.
module fdma_wr_frame_ctrl #(
  parameter logic [20:0] BASE_ADDR   = 21'h0,
  parameter int          FRAME_WORDS = 65536,
  parameter int          BURST_WORDS = 256,
  parameter int          NUM_FRAMES  = 3,
  parameter int          FIFO_DEPTH  = 1024
) (
  input  logic        fdma_clk,
  input  logic        fdma_rstn,
  input  logic        vid_vs,
  input  logic        vid_de,
  input  logic [31:0] vid_data,
  output logic [20:0] fdma_waddr,
  output logic        fdma_wareq,
  output logic [15:0] fdma_wsize,
  input  logic        fdma_wbusy,
  input  logic        fdma_wvalid,
  output logic [31:0] fdma_wdata,
  output logic [1:0]  frame_idx,
  output logic [1:0]  done_idx,
  output logic        frame_done,
  output logic        ovf_flag,
  output logic        unf_flag
);

  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int NUM_BURSTS = FRAME_WORDS / BURST_WORDS;
  localparam int BW         = $clog2(NUM_BURSTS + 1);
  localparam int FW         = $clog2(FRAME_WORDS + 1);

  localparam logic [AW:0]   BURST_THR  = (AW + 1)'(BURST_WORDS);
  localparam logic [BW-1:0] BURST_LAST = BW'(NUM_BURSTS - 1);
  localparam logic [BW-1:0] BURST_END  = BW'(NUM_BURSTS);
  localparam logic [FW-1:0] FRAME_LIM  = FW'(FRAME_WORDS);
  localparam logic [1:0]    FRAME_MAX  = 2'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_BUSY
  } wr_state_t;

  wr_state_t state, state_nxt;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, fifo_cnt;
  logic          fifo_full, fifo_empty, push, pop;
  logic          vs_d, sof_pend, sof_take, burst_go, burst_end;
  logic          last_burst;
  logic [BW-1:0] burst_idx;
  logic [FW-1:0] words_in_frame;
  logic [1:0]    frame_idx_nxt;
  logic [20:0]   addr_calc;

  // The extra pointer MSB distinguishes a full FIFO from an empty one.
  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = vid_de && !fifo_full && !sof_pend && (words_in_frame < FRAME_LIM);
  assign pop        = fdma_wvalid && !fifo_empty;

  assign frame_idx_nxt = (frame_idx == FRAME_MAX) ? 2'd0 : frame_idx + 2'd1;
  assign last_burst    = (burst_idx == BURST_LAST);
  assign addr_calc     = BASE_ADDR + 21'((32'(frame_idx) * 32'(FRAME_WORDS)
                                        + 32'(burst_idx) * 32'(BURST_WORDS)) << 2);

  assign fdma_wsize = 16'(BURST_WORDS);
  assign fdma_wareq = (state == W_REQ);

  always_ff @(posedge fdma_clk or negedge fdma_rstn) begin
    if (!fdma_rstn) begin
      state <= W_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Start-of-frame is only taken between bursts, so a vs edge never cuts a burst short.
  always_comb begin
    state_nxt = state;
    sof_take  = 1'b0;
    burst_go  = 1'b0;
    burst_end = 1'b0;
    case (state)
      W_IDLE: begin
        if (sof_pend) begin
          sof_take = 1'b1;
        end else if ((fifo_cnt >= BURST_THR) && (burst_idx < BURST_END)) begin
          burst_go  = 1'b1;
          state_nxt = W_REQ;
        end
      end
      W_REQ: begin
        if (fdma_wbusy) begin
          state_nxt = W_BUSY;
        end
      end
      W_BUSY: begin
        if (!fdma_wbusy) begin
          burst_end = 1'b1;
          state_nxt = W_IDLE;
        end
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge fdma_clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= vid_data;
    end
  end

  always_ff @(posedge fdma_clk or negedge fdma_rstn) begin
    if (!fdma_rstn) begin
      vs_d           <= 1'b0;
      sof_pend       <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fdma_wdata     <= '0;
      words_in_frame <= '0;
      ovf_flag       <= 1'b0;
      unf_flag       <= 1'b0;
      frame_idx      <= 2'd0;
      done_idx       <= 2'd0;
      burst_idx      <= '0;
      frame_done     <= 1'b0;
      fdma_waddr     <= '0;
    end else begin
      vs_d <= vid_vs;
      if (vid_vs && !vs_d) begin
        sof_pend <= 1'b1;
      end else if (sof_take) begin
        sof_pend <= 1'b0;
      end

      // Servicing a new frame discards whatever is left of the previous one.
      if (sof_take) begin
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        words_in_frame <= '0;
        ovf_flag       <= 1'b0;
        unf_flag       <= 1'b0;
        frame_idx      <= frame_idx_nxt;
        burst_idx      <= '0;
      end else begin
        if (push) begin
          wr_ptr         <= wr_ptr + 1'b1;
          words_in_frame <= words_in_frame + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (vid_de && fifo_full) begin
          ovf_flag <= 1'b1;
        end
        if (fdma_wvalid && fifo_empty) begin
          unf_flag <= 1'b1;
        end
        if (burst_end) begin
          burst_idx <= burst_idx + 1'b1;
        end
      end

      if (pop) begin
        fdma_wdata <= fifo_mem[rd_ptr[AW-1:0]];
      end

      frame_done <= burst_end && last_burst;
      if (burst_end && last_burst) begin
        done_idx <= frame_idx;
      end

      if (burst_go) begin
        fdma_waddr <= addr_calc;
      end
    end
  end

endmodule

// File: tb/tb_fdma_wr_frame_ctrl.sv
// Self-checking bench for fdma_wr_frame_ctrl: a small app_fdma responder plus a queue-based
// reference model of the pixel FIFO, frame rotation and burst addressing.
module tb_fdma_wr_frame_ctrl;

  localparam logic [20:0] BASE    = 21'h1FE000;
  localparam int          FRAME   = 1024;
  localparam int          BURST   = 256;
  localparam int          NFR     = 3;
  localparam int          DEPTH   = 512;
  localparam int          NB      = FRAME / BURST;
  localparam int          TIMEOUT = 5000;

  logic        fdma_clk;
  logic        fdma_rstn;
  logic        vid_vs, vid_de;
  logic [31:0] vid_data;
  logic [20:0] fdma_waddr;
  logic        fdma_wareq;
  logic [15:0] fdma_wsize;
  logic        fdma_wbusy, fdma_wvalid;
  logic [31:0] fdma_wdata;
  logic [1:0]  frame_idx, done_idx;
  logic        frame_done, ovf_flag, unf_flag;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_fifo[$];
  int          m_frame, m_burst, m_words, m_done;
  bit          m_ovf;
  logic [31:0] m_last_wdata;

  fdma_wr_frame_ctrl #(
    .BASE_ADDR  (BASE),
    .FRAME_WORDS(FRAME),
    .BURST_WORDS(BURST),
    .NUM_FRAMES (NFR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .fdma_clk   (fdma_clk),
    .fdma_rstn  (fdma_rstn),
    .vid_vs     (vid_vs),
    .vid_de     (vid_de),
    .vid_data   (vid_data),
    .fdma_waddr (fdma_waddr),
    .fdma_wareq (fdma_wareq),
    .fdma_wsize (fdma_wsize),
    .fdma_wbusy (fdma_wbusy),
    .fdma_wvalid(fdma_wvalid),
    .fdma_wdata (fdma_wdata),
    .frame_idx  (frame_idx),
    .done_idx   (done_idx),
    .frame_done (frame_done),
    .ovf_flag   (ovf_flag),
    .unf_flag   (unf_flag)
  );

  initial begin
    fdma_clk = 1'b0;
    forever #5 fdma_clk = ~fdma_clk;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    fdma_rstn   = 1'b0;
    vid_vs      = 1'b0;
    vid_de      = 1'b0;
    vid_data    = '0;
    fdma_wbusy  = 1'b0;
    fdma_wvalid = 1'b0;
    repeat (3) @(negedge fdma_clk);
    fdma_rstn = 1'b1;
    @(negedge fdma_clk);
    m_fifo.delete();
    m_frame = 0; m_burst = 0; m_words = 0; m_done = 0; m_ovf = 0;
    m_last_wdata = '0;
  endtask

  task automatic model_sof();
    m_fifo.delete();
    m_frame = (m_frame + 1) % NFR;
    m_burst = 0;
    m_words = 0;
    m_ovf   = 0;
  endtask

  task automatic pulse_vs();
    vid_vs = 1'b1;
    @(negedge fdma_clk);
    vid_vs = 1'b0;
    @(negedge fdma_clk);
  endtask

  task automatic vs_idle();
    pulse_vs();
    @(negedge fdma_clk);
    model_sof();
  endtask

  task automatic push_word(input logic [31:0] d);
    vid_de   = 1'b1;
    vid_data = d;
    if (m_fifo.size() >= DEPTH) begin
      m_ovf = 1;
    end else if (m_words < FRAME) begin
      m_fifo.push_back(d);
      m_words++;
    end
    @(negedge fdma_clk);
    vid_de = 1'b0;
  endtask

  task automatic push_words(input int n, input int max_gap, input bit seq);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge fdma_clk);
      push_word(seq ? 32'(i) : $urandom);
    end
  endtask

  // Plays app_fdma for one burst: accept the request, pop BURST words, end the burst.
  task automatic run_burst(input int req_hold, input int pop_delay, input int vs_at);
    int          t;
    int          exp_addr;
    logic [31:0] exp_word;
    bit          last;
    t = 0;
    while (fdma_wareq !== 1'b1 && t < TIMEOUT) begin
      @(negedge fdma_clk);
      t++;
    end
    n_checks++;
    if (fdma_wareq !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL wareq_timeout: wareq=%b required 1 within %0d cycles", fdma_wareq, TIMEOUT);
      return;
    end
    exp_addr = (int'(BASE) + 4 * (m_frame * FRAME + m_burst * BURST)) & 32'h1FFFFF;
    n_checks++;
    if (fdma_waddr !== 21'(exp_addr)) begin
      n_errors++;
      $display("[TB] FAIL waddr: got %h required %h", fdma_waddr, 21'(exp_addr));
    end
    for (int i = 0; i < req_hold; i++) begin
      @(negedge fdma_clk);
      n_checks++;
      if (fdma_wareq !== 1'b1) begin
        n_errors++;
        $display("[TB] FAIL wareq_hold: cycle %0d got %b required 1", i, fdma_wareq);
      end
    end
    fdma_wbusy = 1'b1;
    @(negedge fdma_clk);
    n_checks++;
    if (fdma_wareq !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL wareq_drop: got %b required 0", fdma_wareq);
    end
    repeat (pop_delay) @(negedge fdma_clk);
    for (int i = 0; i < BURST; i++) begin
      repeat ($urandom_range(0, 1)) begin
        fdma_wvalid = 1'b0;
        @(negedge fdma_clk);
      end
      if (i == vs_at) vid_vs = 1'b1;
      fdma_wvalid = 1'b1;
      exp_word = m_fifo.pop_front();
      m_last_wdata = exp_word;
      @(negedge fdma_clk);
      vid_vs = 1'b0;
      n_checks++;
      if (fdma_wdata !== exp_word) begin
        n_errors++;
        $display("[TB] FAIL wdata: word %0d got %h required %h", i, fdma_wdata, exp_word);
      end
    end
    fdma_wvalid = 1'b0;
    repeat (2) @(negedge fdma_clk);
    fdma_wbusy = 1'b0;
    last = (m_burst == NB - 1);
    m_burst++;
    if (last) m_done = m_frame;
    @(negedge fdma_clk);
    n_checks++;
    if (frame_done !== last || fdma_wareq !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL burst_end: frame_done=%b wareq=%b required %b/0", frame_done, fdma_wareq, last);
    end
    n_checks++;
    if (done_idx !== 2'(m_done)) begin
      n_errors++;
      $display("[TB] FAIL done_idx: got %0d required %0d", done_idx, m_done);
    end
    @(negedge fdma_clk);
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL frame_done_pulse: got %b required 0", frame_done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (fdma_waddr !== 21'h0 || fdma_wareq !== 1'b0 || fdma_wdata !== 32'h0 ||
        frame_idx !== 2'd0 || done_idx !== 2'd0 || frame_done !== 1'b0 ||
        ovf_flag !== 1'b0 || unf_flag !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_state: waddr=%h wareq=%b wdata=%h fidx=%0d didx=%0d done=%b ovf=%b unf=%b required all 0",
               fdma_waddr, fdma_wareq, fdma_wdata, frame_idx, done_idx, frame_done, ovf_flag, unf_flag);
    end
    n_checks++;
    if (fdma_wsize !== 16'd256) begin
      n_errors++;
      $display("[TB] FAIL wsize: got %0d required 256", fdma_wsize);
    end
  endtask

  task automatic test_single_burst();
    bit seen;
    do_reset();
    vs_idle();
    n_checks++;
    if (frame_idx !== 2'd1) begin
      n_errors++;
      $display("[TB] FAIL first_frame_idx: got %0d required 1", frame_idx);
    end
    push_words(BURST, 0, 1'b1);
    run_burst($urandom_range(0, 3), 256, -1);
    seen = 0;
    repeat (10) begin
      @(negedge fdma_clk);
      if (fdma_wareq) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("[TB] FAIL single_request: extra wareq seen=1 required 0");
    end
    fdma_wvalid = 1'b1;
    @(negedge fdma_clk);
    fdma_wvalid = 1'b0;
    @(negedge fdma_clk);
    n_checks++;
    if (unf_flag !== 1'b1 || fdma_wdata !== m_last_wdata) begin
      n_errors++;
      $display("[TB] FAIL underflow: unf=%b wdata=%h required 1/%h", unf_flag, fdma_wdata, m_last_wdata);
    end
    vs_idle();
    n_checks++;
    if (unf_flag !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL unf_clear: got %b required 0", unf_flag);
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    vs_idle();
    fork
      push_words(FRAME, 3, 1'b0);
      repeat (NB) run_burst($urandom_range(0, 3), 0, -1);
    join
    n_checks++;
    if (done_idx !== 2'd1) begin
      n_errors++;
      $display("[TB] FAIL full_frame_done_idx: got %0d required 1", done_idx);
    end
  endtask

  task automatic test_frame_rotation();
    int exp_seq[4];
    exp_seq = '{1, 2, 0, 1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      vs_idle();
      n_checks++;
      if (frame_idx !== 2'(exp_seq[k])) begin
        n_errors++;
        $display("[TB] FAIL rotation_frame_idx: frame %0d got %0d required %0d", k, frame_idx, exp_seq[k]);
      end
      fork
        push_words(FRAME, 3, 1'b0);
        repeat (NB) run_burst($urandom_range(0, 3), 0, -1);
      join
      n_checks++;
      if (done_idx !== 2'(exp_seq[k])) begin
        n_errors++;
        $display("[TB] FAIL rotation_done_idx: frame %0d got %0d required %0d", k, done_idx, exp_seq[k]);
      end
    end
  endtask

  task automatic test_wbusy_late();
    bit seen;
    do_reset();
    vs_idle();
    push_words(BURST, 1, 1'b0);
    run_burst(20, 0, -1);
    seen = 0;
    repeat (10) begin
      @(negedge fdma_clk);
      if (fdma_wareq) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("[TB] FAIL one_burst_only: extra wareq seen=1 required 0");
    end
  endtask

  task automatic test_vs_mid_burst();
    bit seen;
    do_reset();
    vs_idle();
    push_words(300, 0, 1'b0);
    run_burst(1, 0, 100);
    model_sof();
    n_checks++;
    if (frame_idx !== 2'd2) begin
      n_errors++;
      $display("[TB] FAIL vs_mid_frame_idx: got %0d required 2", frame_idx);
    end
    push_words(BURST - 1, 0, 1'b0);
    seen = 0;
    repeat (10) begin
      @(negedge fdma_clk);
      if (fdma_wareq) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("[TB] FAIL flush_no_req: wareq seen=1 required 0 with %0d fresh words", BURST - 1);
    end
    push_words(1, 0, 1'b0);
    run_burst(0, 0, -1);
  endtask

  task automatic test_overflow();
    do_reset();
    vs_idle();
    push_words(DEPTH, 0, 1'b0);
    @(negedge fdma_clk);
    n_checks++;
    if (ovf_flag !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL ovf_at_full: got %b required 0", ovf_flag);
    end
    push_words(8, 0, 1'b0);
    n_checks++;
    if (ovf_flag !== 1'b1 || m_ovf !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL ovf_set: got %b required 1", ovf_flag);
    end
    pulse_vs();
    repeat (3) @(negedge fdma_clk);
    n_checks++;
    if (ovf_flag !== 1'b1 || frame_idx !== 2'd1) begin
      n_errors++;
      $display("[TB] FAIL vs_deferred: ovf=%b fidx=%0d required 1/1", ovf_flag, frame_idx);
    end
    run_burst(0, 0, -1);
    model_sof();
    n_checks++;
    if (ovf_flag !== 1'b0 || frame_idx !== 2'd2) begin
      n_errors++;
      $display("[TB] FAIL ovf_clear: ovf=%b fidx=%0d required 0/2", ovf_flag, frame_idx);
    end
  endtask

  task automatic test_reset_mid_burst();
    int t;
    do_reset();
    vs_idle();
    push_words(BURST, 0, 1'b0);
    t = 0;
    while (fdma_wareq !== 1'b1 && t < TIMEOUT) begin
      @(negedge fdma_clk);
      t++;
    end
    fdma_wbusy = 1'b1;
    repeat (2) @(negedge fdma_clk);
    fdma_wvalid = 1'b1;
    @(negedge fdma_clk);
    fdma_wvalid = 1'b0;
    fdma_rstn = 1'b0;
    #1;
    n_checks++;
    if (fdma_wareq !== 1'b0 || frame_idx !== 2'd0 || fdma_waddr !== 21'h0 || fdma_wdata !== 32'h0) begin
      n_errors++;
      $display("[TB] FAIL reset_mid_burst: wareq=%b fidx=%0d waddr=%h wdata=%h required 0",
               fdma_wareq, frame_idx, fdma_waddr, fdma_wdata);
    end
    fdma_wbusy = 1'b0;
    do_reset();
  endtask

  initial begin
    $display("[TB] starting fdma_wr_frame_ctrl bench");
    test_reset();
    test_single_burst();
    test_full_frame();
    test_frame_rotation();
    test_wbusy_late();
    test_vs_mid_burst();
    test_overflow();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
